instr_sequencer: RTL and testbench

//  Program sequencer that feeds 16-bit instructions to the 4-bit ALU/register-file processor datapath.

---
 rtl/seq_pkg.sv | 31 +++
 rtl/instr_sequencer_if.sv | 38 +++
 rtl/seq_prog_mem.sv | 37 +++
 rtl/instr_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_instr_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared types and constants for the instruction sequencer:
//               FSM state encoding, opcode values and instruction field
//               positions.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int INST_W     = 16;
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 3;

    localparam logic [OPCODE_W-1:0] OP_REGWRITE = 3'b011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH   = 3'b101;

    // Extract the opcode field of an instruction word
    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
        return inst[OPCODE_LSB +: OPCODE_W];
    endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Instruction issue channel between the sequencer (master) and
//               the ALU/register-file datapath (slave). Carries the
//               valid/ready handshake, the instruction, its slot index and
//               the ALU zero flag returned for the presented instruction.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if
    import seq_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic              issue_valid;
    logic              issue_ready;
    logic [INST_W-1:0] issue_inst;
    logic [ADDR_W-1:0] issue_pc;
    logic              zero_in;

    modport master (
        output issue_valid,
        output issue_inst,
        output issue_pc,
        input  issue_ready,
        input  zero_in
    );

    modport slave (
        input  issue_valid,
        input  issue_inst,
        input  issue_pc,
        output issue_ready,
        output zero_in
    );

endinterface : instr_sequencer_if
`default_nettype wire

// File: rtl/seq_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : seq_prog_mem
// Description : Program buffer: DEPTH x DATA_W register array with one
//               synchronous write port and one combinational read port.
//               Contents are intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_prog_mem
    import seq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = INST_W
)
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port: one word per cycle when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : seq_prog_mem
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Program sequencer for the 4-bit ALU/register-file datapath.
//               Instructions are loaded byte-wise (low byte first) into a
//               program buffer while idle; on start the buffer is replayed
//               over a valid/ready issue channel for loop_cnt+1 passes.
//               halt_req aborts a run; done pulses for one cycle at the end.
//               Optional feature macro: SEQ_BRANCH_EN - consume opcode
//               3'b101 internally as branch-if-zero on the last issued
//               instruction's ALU zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PROG_DEPTH = 16
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [7:0]                    load_byte,
    input  logic                          start,
    input  logic [7:0]                    loop_cnt,
    input  logic                          halt_req,
    instr_sequencer_if.master             iss,
    output logic [$clog2(PROG_DEPTH):0]   prog_len,
    output logic                          busy,
    output logic                          done
);

    localparam int ADDR_W = $clog2(PROG_DEPTH);
    localparam logic [ADDR_W:0] c_PROG_DEPTH = (ADDR_W+1)'(PROG_DEPTH);

    seq_state_e        r_state, w_state_nxt;
    logic [ADDR_W:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic              r_phase, w_phase_nxt;
    logic [7:0]        r_lo_hold, w_lo_hold_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [7:0]        r_loops_left, w_loops_left_nxt;

    logic              w_mem_we;
    logic [INST_W-1:0] w_mem_wdata;
    logic [INST_W-1:0] w_inst;
    logic              w_load_fire;
    logic              w_handshake;
    logic              w_advance;
    logic [ADDR_W:0]   w_pc_seq;
    logic [ADDR_W:0]   w_pc_target;

    seq_prog_mem #(
        .DEPTH  (PROG_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (INST_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (r_wr_ptr[ADDR_W-1:0]),
        .wdata (w_mem_wdata),
        .raddr (r_pc),
        .rdata (w_inst)
    );

    assign load_ready  = (r_state == IDLE) && (r_wr_ptr < c_PROG_DEPTH);
    // clear wins over a load offered in the same cycle
    assign w_load_fire = load_valid && load_ready && !clear;
    assign w_mem_wdata = {load_byte, r_lo_hold};
    assign w_pc_seq    = {1'b0, r_pc} + (ADDR_W+1)'(1);

`ifdef SEQ_BRANCH_EN
    logic r_zflag;
    logic w_is_branch;

    // Branches are never presented to the datapath; they take one RUN cycle
    assign w_is_branch     = (opcode_of(w_inst) == OP_BRANCH);
    assign iss.issue_valid = (r_state == RUN) && !w_is_branch;
    assign w_pc_target     = (w_is_branch && r_zflag) ?
                             {1'b0, w_inst[INST_W-1 -: ADDR_W]} : w_pc_seq;
    assign w_advance       = w_handshake || ((r_state == RUN) && w_is_branch);

    // Zero flag of the most recently accepted instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zflag <= 1'b0;
        end else if (w_handshake) begin
            r_zflag <= iss.zero_in;
        end
    end
`else
    logic w_unused_zero;

    assign iss.issue_valid = (r_state == RUN);
    assign w_pc_target     = w_pc_seq;
    assign w_advance       = w_handshake;
    assign w_unused_zero   = iss.zero_in;
`endif

    assign w_handshake    = iss.issue_valid && iss.issue_ready;
    // pc only moves on advance, so inst/pc stay stable while ready is low
    assign iss.issue_inst = (r_state == RUN) ? w_inst : '0;
    assign iss.issue_pc   = (r_state == RUN) ? r_pc   : '0;

    assign prog_len = r_wr_ptr;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);

    // State, pointer and loop-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_phase      <= 1'b0;
            r_lo_hold    <= '0;
            r_pc         <= '0;
            r_loops_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_phase      <= w_phase_nxt;
            r_lo_hold    <= w_lo_hold_nxt;
            r_pc         <= w_pc_nxt;
            r_loops_left <= w_loops_left_nxt;
        end
    end

    // Next-state: byte loading and start while idle, issue sequencing in RUN
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_phase_nxt      = r_phase;
        w_lo_hold_nxt    = r_lo_hold;
        w_pc_nxt         = r_pc;
        w_loops_left_nxt = r_loops_left;
        w_mem_we         = 1'b0;

        case (r_state)
            IDLE: begin
                if (clear) begin
                    w_wr_ptr_nxt = '0;
                    w_phase_nxt  = 1'b0;
                end else if (w_load_fire) begin
                    if (!r_phase) begin
                        w_lo_hold_nxt = load_byte;
                        w_phase_nxt   = 1'b1;
                    end else begin
                        w_mem_we     = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + (ADDR_W+1)'(1);
                        w_phase_nxt  = 1'b0;
                    end
                end
                // A half-loaded word blocks start
                if (start && !r_phase) begin
                    w_pc_nxt         = '0;
                    w_loops_left_nxt = loop_cnt;
                    w_state_nxt      = (r_wr_ptr == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                // Abort beats end-of-pass wrap; a same-cycle handshake still completes
                if (halt_req) begin
                    w_state_nxt = DONE;
                end else if (w_advance) begin
                    if (w_pc_target >= r_wr_ptr) begin
                        if (r_loops_left == 8'd0) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_loops_left_nxt = r_loops_left - 8'd1;
                            w_pc_nxt         = '0;
                        end
                    end else begin
                        w_pc_nxt = w_pc_target[ADDR_W-1:0];
                    end
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule : instr_sequencer
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer. Expected issues are
//               queued when a run is launched and compared as the DUT
//               presents them; handshakes retire queue entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int PROG_DEPTH = 16;
    localparam int ADDR_W     = 4;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [15:0]       inst;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              load_valid;
    logic              load_ready;
    logic [7:0]        load_byte;
    logic              start;
    logic [7:0]        loop_cnt;
    logic              halt_req;
    logic [ADDR_W:0]   prog_len;
    logic              busy;
    logic              done;

    instr_sequencer_if #(.ADDR_W(ADDR_W)) iss ();

    instr_sequencer #(.PROG_DEPTH(PROG_DEPTH)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_byte  (load_byte),
        .start      (start),
        .loop_cnt   (loop_cnt),
        .halt_req   (halt_req),
        .iss        (iss.master),
        .prog_len   (prog_len),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    exp_t        sb_q[$];
    logic [15:0] model_mem [PROG_DEPTH];
    int          model_len = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] word_of(input int i);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'(8'hA0 + i);
        lo = 8'(8'h03 + (i << 4));
        return {hi, lo};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        if (model_len < PROG_DEPTH) begin
            model_mem[model_len] = w;
            model_len++;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_len = 0;
    endtask

    task automatic push_exp(input int n, input int passes);
        exp_t e;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < n; k++) begin
                e.pc   = ADDR_W'(k);
                e.inst = model_mem[k];
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic run_wait(input logic [7:0] loops, input bit toggle);
        int d0;
        d0       = done_cnt;
        loop_cnt = loops;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400 && busy; c++) begin
            if (toggle) iss.issue_ready = ~iss.issue_ready;
            tick();
        end
        check("run_finished", 32'(busy), 0);
        check("done_pulses", 32'(done_cnt - d0), 1);
        check("sb_drained", 32'(sb_q.size()), 0);
        sb_q.delete();
        iss.issue_ready = 1'b1;
    endtask

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (iss.issue_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_issue", 32'(sb_q.size()), 1);
            end else begin
                check("issue_pc", 32'(iss.issue_pc), 32'(sb_q[0].pc));
                check("issue_inst", 32'(iss.issue_inst), 32'(sb_q[0].inst));
                if (iss.issue_ready === 1'b1) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        int d0;
        rst             = 1'b1;
        clear           = 1'b0;
        load_valid      = 1'b0;
        load_byte       = '0;
        start           = 1'b0;
        loop_cnt        = '0;
        halt_req        = 1'b0;
        iss.issue_ready = 1'b0;
        iss.zero_in     = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_load_ready", 32'(load_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(iss.issue_valid), 0);
        check("rst_prog_len", 32'(prog_len), 0);
        check("rst_inst", 32'(iss.issue_inst), 0);
        rst = 1'b0;
        tick();

        // 1: four words, single pass, back-to-back issue
        for (int i = 0; i < 4; i++) load_word(word_of(i));
        check("t1_prog_len", 32'(prog_len), 4);
        push_exp(4, 1);
        d0              = done_cnt;
        iss.issue_ready = 1'b1;
        loop_cnt        = 8'd0;
        start           = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t1_valid", 32'(iss.issue_valid), 1);
            check("t1_pc", 32'(iss.issue_pc), 32'(k));
            tick();
        end
        check("t1_done", 32'(done), 1);
        check("t1_valid_off", 32'(iss.issue_valid), 0);
        tick();
        check("t1_done_clear", 32'(done), 0);
        check("t1_busy_clear", 32'(busy), 0);
        check("t1_done_count", 32'(done_cnt - d0), 1);
        check("t1_sb_drained", 32'(sb_q.size()), 0);
        sb_q.delete();

        // 2: three passes with ready toggling
        push_exp(4, 3);
        iss.issue_ready = 1'b1;
        run_wait(8'd2, 1'b1);

        // 4: halt on the second issue cycle with ready low
        push_exp(2, 1);
        d0              = done_cnt;
        iss.issue_ready = 1'b1;
        loop_cnt        = 8'd0;
        start           = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t4_valid_pc1", 32'(iss.issue_valid), 1);
        check("t4_pc1", 32'(iss.issue_pc), 1);
        iss.issue_ready = 1'b0;
        halt_req        = 1'b1;
        tick();
        halt_req = 1'b0;
        check("t4_valid_drop", 32'(iss.issue_valid), 0);
        check("t4_done", 32'(done), 1);
        tick();
        check("t4_busy_after", 32'(busy), 0);
        check("t4_done_count", 32'(done_cnt - d0), 1);
        check("t4_pending", 32'(sb_q.size()), 1);
        sb_q.delete();
        push_exp(4, 1);
        iss.issue_ready = 1'b1;
        run_wait(8'd0, 1'b0);

        // 5: half-loaded word blocks start; empty program finishes at once
        do_clear();
        check("t5_cleared", 32'(prog_len), 0);
        load_word(16'h5A13);
        send_byte(8'h2B);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_start_ignored", 32'(busy), 0);
        send_byte(8'hC4);
        model_mem[1] = 16'hC42B;
        model_len    = 2;
        check("t5_prog_len", 32'(prog_len), 2);
        push_exp(2, 1);
        run_wait(8'd0, 1'b0);
        do_clear();
        d0    = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_empty_done", 32'(done), 1);
        check("t5_empty_valid", 32'(iss.issue_valid), 0);
        tick();
        check("t5_empty_idle", 32'(busy), 0);
        check("t5_empty_done_count", 32'(done_cnt - d0), 1);

        // 3: fill the buffer, extra bytes are dropped
        do_clear();
        for (int i = 0; i < PROG_DEPTH - 1; i++) load_word(word_of(i + 5));
        check("t3_ready_not_full", 32'(load_ready), 1);
        load_word(word_of(PROG_DEPTH + 5));
        check("t3_ready_full", 32'(load_ready), 0);
        check("t3_prog_len", 32'(prog_len), PROG_DEPTH);
        send_byte(8'hFF);
        send_byte(8'hEE);
        check("t3_prog_len_kept", 32'(prog_len), PROG_DEPTH);
        push_exp(PROG_DEPTH, 1);
        run_wait(8'd0, 1'b0);

`ifdef SEQ_BRANCH_EN
        // 6: branch-if-zero consumed internally
        do_clear();
        load_word(16'h0010);
        load_word(16'h0005);
        load_word(16'h0F23);
        // taken: 0, 1 (not issued), 0 ...then halt
        push_exp(1, 2);
        iss.zero_in     = 1'b1;
        iss.issue_ready = 1'b1;
        loop_cnt        = 8'd0;
        start           = 1'b1;
        tick();
        start = 1'b0;
        check("t6_first_pc", 32'(iss.issue_pc), 0);
        tick();
        check("t6_branch_no_valid", 32'(iss.issue_valid), 0);
        tick();
        check("t6_taken_valid", 32'(iss.issue_valid), 1);
        check("t6_taken_pc", 32'(iss.issue_pc), 0);
        iss.issue_ready = 1'b0;
        halt_req        = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        check("t6_halt_idle", 32'(busy), 0);
        check("t6_pending", 32'(sb_q.size()), 1);
        sb_q.delete();
        // not taken: 0, 1 (not issued), 2
        model_mem[1] = model_mem[2];
        sb_q.push_back('{pc: 4'd0, inst: 16'h0010});
        sb_q.push_back('{pc: 4'd2, inst: 16'h0F23});
        iss.zero_in     = 1'b0;
        iss.issue_ready = 1'b1;
        run_wait(8'd0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_instr_sequencer
`default_nettype wire
